// File: rtl/smi_arb_2to1.sv
// smi_arb_2to1: arbitrates two SMI requesters onto one memory port and
// routes in-order responses back via an ID FIFO of requester grants.
// Optional macro SMI_ARB_FIXED_PRIORITY_EN: A always wins ties (else round-robin).
module smi_arb_2to1 #(
    parameter int OUTSTANDING_LOG2 = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        smireqa_0Ready,
    input  logic [71:0] smireqa_0Data,
    output logic        smireqa_0Stop,
    input  logic        smireqb_0Ready,
    input  logic [71:0] smireqb_0Data,
    output logic        smireqb_0Stop,
    output logic        smirespa_0Ready,
    output logic [71:0] smirespa_0Data,
    input  logic        smirespa_0Stop,
    output logic        smirespb_0Ready,
    output logic [71:0] smirespb_0Data,
    input  logic        smirespb_0Stop,
    output logic        smiportreq_0Ready,
    output logic [71:0] smiportreq_0Data,
    input  logic        smiportreq_0Stop,
    input  logic        smiportresp_0Ready,
    input  logic [71:0] smiportresp_0Data,
    output logic        smiportresp_0Stop
);

    localparam int DEPTH = 1 << OUTSTANDING_LOG2;
    localparam logic [OUTSTANDING_LOG2-1:0] PTR_ONE = 1;
    localparam logic [OUTSTANDING_LOG2:0] CNT_ONE = 1;
    localparam logic [OUTSTANDING_LOG2:0] CNT_FULL = (OUTSTANDING_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FWD_A = 2'd1,
        FWD_B = 2'd2
    } state_t;

    state_t                    r_state;
    logic                      r_fifo [DEPTH];
    logic [OUTSTANDING_LOG2-1:0] r_wptr;
    logic [OUTSTANDING_LOG2-1:0] r_rptr;
    logic [OUTSTANDING_LOG2:0]   r_count;

    logic w_fwd_a;
    logic w_fwd_b;
    logic w_full;
    logic w_have_head;
    logic w_head;
    logic w_win_b;
    logic w_grant;
    logic w_req_done;
    logic w_pop;

    // Reset gates the steering so outputs are quiet while reset is held.
    assign w_fwd_a     = (r_state == FWD_A) & ~reset;
    assign w_fwd_b     = (r_state == FWD_B) & ~reset;
    assign w_full      = (r_count == CNT_FULL);
    assign w_have_head = (r_count != '0) & ~reset;
    assign w_head      = r_fifo[r_rptr];

`ifdef SMI_ARB_FIXED_PRIORITY_EN
    assign w_win_b = ~smireqa_0Ready;
`else
    logic r_favour_b;

    assign w_win_b = smireqb_0Ready & (~smireqa_0Ready | r_favour_b);

    // Round-robin pointer: favour the requester not granted last.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_favour_b <= 1'b0;
        end else if (w_grant) begin
            r_favour_b <= ~w_win_b;
        end
    end
`endif

    assign w_grant = (r_state == IDLE)
                   & (smireqa_0Ready | smireqb_0Ready)
                   & ~w_full;

    assign w_req_done = smiportreq_0Ready & ~smiportreq_0Stop
                      & smiportreq_0Data[64];

    assign w_pop = smiportresp_0Ready & ~smiportresp_0Stop
                 & smiportresp_0Data[64];

    // Request steering: the granted requester talks straight to the port.
    always_comb begin
        smiportreq_0Ready = 1'b0;
        smiportreq_0Data  = smireqa_0Data;
        smireqa_0Stop     = 1'b1;
        smireqb_0Stop     = 1'b1;
        if (w_fwd_a) begin
            smiportreq_0Ready = smireqa_0Ready;
            smireqa_0Stop     = smiportreq_0Stop;
        end else if (w_fwd_b) begin
            smiportreq_0Ready = smireqb_0Ready;
            smiportreq_0Data  = smireqb_0Data;
            smireqb_0Stop     = smiportreq_0Stop;
        end
    end

    // Response steering: only Ready is routed, to the oldest grant.
    always_comb begin
        smirespa_0Ready   = w_have_head & ~w_head & smiportresp_0Ready;
        smirespb_0Ready   = w_have_head &  w_head & smiportresp_0Ready;
        smiportresp_0Stop = 1'b1;
        if (w_have_head) begin
            smiportresp_0Stop = w_head ? smirespb_0Stop : smirespa_0Stop;
        end
    end

    assign smirespa_0Data = smiportresp_0Data;
    assign smirespb_0Data = smiportresp_0Data;

    // Request FSM: hold a grant until the frame's EOF flit transfers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_state <= w_win_b ? FWD_B : FWD_A;
                    end
                end
                FWD_A, FWD_B: begin
                    if (w_req_done) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // ID FIFO storage; contents are don't-care while the count is zero.
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_fifo[r_wptr] <= w_win_b;
        end
    end

    // ID FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_grant) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            unique case ({w_grant, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_smi_arb_2to1.sv
// tb_smi_arb_2to1: directed bench with a queue-based transaction model
// checked against the DUT on every falling edge.
module tb_smi_arb_2to1;

    localparam int DEPTH = 4;
`ifdef SMI_ARB_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_rdy, b_rdy, pr_rdy;
    logic [71:0] a_dat, b_dat, pr_dat;
    logic        pq_stop, ra_stop, rb_stop;

    logic        smireqa_0Stop, smireqb_0Stop;
    logic        smirespa_0Ready, smirespb_0Ready;
    logic [71:0] smirespa_0Data, smirespb_0Data;
    logic        smiportreq_0Ready;
    logic [71:0] smiportreq_0Data;
    logic        smiportresp_0Stop;

    smi_arb_2to1 #(.OUTSTANDING_LOG2(2)) dut (
        .clk                (clk),
        .reset              (reset),
        .smireqa_0Ready     (a_rdy),
        .smireqa_0Data      (a_dat),
        .smireqa_0Stop      (smireqa_0Stop),
        .smireqb_0Ready     (b_rdy),
        .smireqb_0Data      (b_dat),
        .smireqb_0Stop      (smireqb_0Stop),
        .smirespa_0Ready    (smirespa_0Ready),
        .smirespa_0Data     (smirespa_0Data),
        .smirespa_0Stop     (ra_stop),
        .smirespb_0Ready    (smirespb_0Ready),
        .smirespb_0Data     (smirespb_0Data),
        .smirespb_0Stop     (rb_stop),
        .smiportreq_0Ready  (smiportreq_0Ready),
        .smiportreq_0Data   (smiportreq_0Data),
        .smiportreq_0Stop   (pq_stop),
        .smiportresp_0Ready (pr_rdy),
        .smiportresp_0Data  (pr_dat),
        .smiportresp_0Stop  (smiportresp_0Stop)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [71:0] a_q[$], b_q[$], r_q[$];
    bit fa, fb, fr;

    int          m_owner = -1;
    int          m_ids[$];
    bit          m_favb = 1'b0;
    int          cyc = 0;
    int          g_log[$], g_cyc[$], pq_cyc[$], rt_log[$];
    logic [71:0] pq_log[$];
    int          pop_cyc = 0;
    int          ra_n = 0, rb_n = 0;

    task automatic chk1(string n, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b", n, act, exp);
        end
    endtask

    task automatic chkd(string n, logic [71:0] act, logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", n, act, exp);
        end
    endtask

    task automatic chki(string n, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", n, act, exp);
        end
    endtask

    function automatic logic [71:0] flit(int src, int n, bit eof);
        logic [71:0] f;
        f = '0;
        f[71:68] = 4'(src);
        f[64] = eof;
        f[15:0] = 16'(n);
        return f;
    endfunction

    // Model: owner of the port, list of outstanding grants, tie-break flag.
    always @(negedge clk) begin
        int own, head, win, sz;
        logic e_pqr, e_sa, e_sb, e_rar, e_rbr, e_prs;
        logic [71:0] e_pqd;
        bit pq_x, pr_x;
        cyc++;
        own  = reset ? -1 : m_owner;
        head = (!reset && m_ids.size() > 0) ? m_ids[0] : -1;
        e_pqr = (own == 0) ? a_rdy : (own == 1) ? b_rdy : 1'b0;
        e_pqd = (own == 1) ? b_dat : a_dat;
        e_sa  = (own == 0) ? pq_stop : 1'b1;
        e_sb  = (own == 1) ? pq_stop : 1'b1;
        e_rar = (head == 0) && pr_rdy;
        e_rbr = (head == 1) && pr_rdy;
        e_prs = (head == 0) ? ra_stop : (head == 1) ? rb_stop : 1'b1;

        chk1("pq_ready", smiportreq_0Ready, e_pqr);
        chk1("reqa_stop", smireqa_0Stop, e_sa);
        chk1("reqb_stop", smireqb_0Stop, e_sb);
        chk1("respa_ready", smirespa_0Ready, e_rar);
        chk1("respb_ready", smirespb_0Ready, e_rbr);
        chk1("presp_stop", smiportresp_0Stop, e_prs);
        chkd("respa_data", smirespa_0Data, pr_dat);
        chkd("respb_data", smirespb_0Data, pr_dat);
        if (own >= 0) chkd("pq_data", smiportreq_0Data, e_pqd);

        fa = a_rdy && !smireqa_0Stop;
        fb = b_rdy && !smireqb_0Stop;
        fr = pr_rdy && !smiportresp_0Stop;

        pq_x = e_pqr && !pq_stop;
        pr_x = pr_rdy && !e_prs;
        sz   = m_ids.size();
        if (reset) begin
            m_owner = -1;
            m_ids.delete();
            m_favb = 1'b0;
        end else begin
            if (pq_x) begin
                pq_log.push_back(e_pqd);
                pq_cyc.push_back(cyc);
            end
            if (own >= 0) begin
                if (pq_x && e_pqd[64]) m_owner = -1;
            end else if ((a_rdy || b_rdy) && sz < DEPTH) begin
                if (a_rdy && b_rdy) win = FIXED ? 0 : (m_favb ? 1 : 0);
                else win = a_rdy ? 0 : 1;
                m_favb = (win == 0);
                m_owner = win;
                m_ids.push_back(win);
                g_log.push_back(win);
                g_cyc.push_back(cyc);
            end
            if (pr_x) begin
                if (head == 0) ra_n++;
                else rb_n++;
                if (pr_dat[64]) begin
                    rt_log.push_back(head);
                    void'(m_ids.pop_front());
                    pop_cyc = cyc;
                end
            end
        end
    end

    task automatic drive();
        a_rdy  = a_q.size() > 0;
        a_dat  = a_rdy ? a_q[0] : '0;
        b_rdy  = b_q.size() > 0;
        b_dat  = b_rdy ? b_q[0] : '0;
        pr_rdy = r_q.size() > 0;
        pr_dat = pr_rdy ? r_q[0] : '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (fa && a_q.size() > 0) void'(a_q.pop_front());
        if (fb && b_q.size() > 0) void'(b_q.pop_front());
        if (fr && r_q.size() > 0) void'(r_q.pop_front());
        drive();
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic push_frame(int who, int src, int nf);
        for (int i = 0; i < nf; i++) begin
            if (who == 0) a_q.push_back(flit(src, i, i == nf - 1));
            else if (who == 1) b_q.push_back(flit(src, i, i == nf - 1));
            else r_q.push_back(flit(src, i, i == nf - 1));
        end
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a_q.delete();
        b_q.delete();
        r_q.delete();
        drive();
        run(2);
        reset = 1'b0;
    endtask

    initial begin
        int base, gbase, t0, ra0, rb0, rbase;
        int exp_g[4];
        pq_stop = 1'b0;
        ra_stop = 1'b0;
        rb_stop = 1'b0;
        drive();
        run(2);
        chk1("rst_pq_ready", smiportreq_0Ready, 1'b0);
        chk1("rst_presp_stop", smiportresp_0Stop, 1'b1);
        chk1("rst_reqa_stop", smireqa_0Stop, 1'b1);
        chk1("rst_reqb_stop", smireqb_0Stop, 1'b1);
        reset = 1'b0;
        step();

        // One 3-flit frame from A, then a 2-flit response.
        base = pq_log.size();
        gbase = g_log.size();
        t0 = cyc;
        push_frame(0, 10, 3);
        run(8);
        chki("t1_flits", pq_log.size() - base, 3);
        chki("t1_grant_lat", g_cyc[gbase] - t0, 1);
        chki("t1_flit_lat", pq_cyc[base] - t0, 2);
        chkd("t1_flit0", pq_log[base], flit(10, 0, 0));
        chkd("t1_flit2", pq_log[base + 2], flit(10, 2, 1));
        ra0 = ra_n;
        rb0 = rb_n;
        push_frame(2, 12, 2);
        run(6);
        chki("t1_resp_a", ra_n - ra0, 2);
        chki("t1_resp_b", rb_n - rb0, 0);

        // Response with nothing outstanding must be stopped.
        push_frame(2, 15, 1);
        #1;
        chk1("t1_empty_stop", smiportresp_0Stop, 1'b1);
        chk1("t1_empty_ra", smirespa_0Ready, 1'b0);
        run(2);
        r_q.delete();
        drive();

        // Both requesters, two single-flit frames each.
        do_reset();
        gbase = g_log.size();
        if (FIXED) exp_g = '{0, 0, 1, 1};
        else exp_g = '{0, 1, 0, 1};
        push_frame(0, 10, 1);
        push_frame(0, 10, 1);
        push_frame(1, 11, 1);
        push_frame(1, 11, 1);
        run(16);
        chki("t2_grants", g_log.size() - gbase, 4);
        for (int i = 0; i < 4; i++) chki("t2_order", g_log[gbase + i], exp_g[i]);
        rbase = rt_log.size();
        for (int i = 0; i < 4; i++) push_frame(2, 12, 1);
        run(8);
        chki("t2_routes", rt_log.size() - rbase, 4);
        for (int i = 0; i < 4; i++) chki("t2_route", rt_log[rbase + i], exp_g[i]);

        // Port stall in the middle of A's frame with B waiting.
        do_reset();
        base = pq_log.size();
        gbase = g_log.size();
        push_frame(0, 10, 3);
        push_frame(1, 11, 1);
        for (int i = 0; i < 10 && pq_log.size() <= base; i++) step();
        pq_stop = 1'b1;
        run(4);
        chki("t3_held_flits", pq_log.size() - base, 1);
        chki("t3_no_b_grant", g_log.size() - gbase, 1);
        pq_stop = 1'b0;
        run(10);
        chki("t3_flits", pq_log.size() - base, 4);
        chkd("t3_a1", pq_log[base + 1], flit(10, 1, 0));
        chkd("t3_a2", pq_log[base + 2], flit(10, 2, 1));
        chkd("t3_b0", pq_log[base + 3], flit(11, 0, 1));
        chki("t3_g1", g_log[gbase + 1], 1);

        // Five frames with no responses: the fifth waits for a pop.
        do_reset();
        gbase = g_log.size();
        for (int i = 0; i < 3; i++) push_frame(0, 10, 1);
        for (int i = 0; i < 2; i++) push_frame(1, 11, 1);
        run(20);
        chki("t4_grants", g_log.size() - gbase, 4);
        chki("t4_left", a_q.size() + b_q.size(), 1);
        chk1("t4_reqa_stop", smireqa_0Stop, 1'b1);
        chk1("t4_reqb_stop", smireqb_0Stop, 1'b1);
        chk1("t4_pq_ready", smiportreq_0Ready, 1'b0);
        push_frame(2, 12, 1);
        run(6);
        chki("t4_fifth", g_log.size() - gbase, 5);
        chki("t4_pop_to_grant", g_cyc[g_cyc.size() - 1] - pop_cyc, 1);

        // Reset during the second flit of a 4-flit frame.
        do_reset();
        base = pq_log.size();
        gbase = g_log.size();
        push_frame(0, 10, 4);
        for (int i = 0; i < 10 && pq_log.size() <= base; i++) step();
        chki("t5_first", pq_log.size() - base, 1);
        reset = 1'b1;
        a_q.delete();
        drive();
        step();
        push_frame(2, 12, 1);
        #1;
        chk1("t5_pq_ready", smiportreq_0Ready, 1'b0);
        chk1("t5_ra_ready", smirespa_0Ready, 1'b0);
        chk1("t5_rb_ready", smirespb_0Ready, 1'b0);
        chk1("t5_presp_stop", smiportresp_0Stop, 1'b1);
        r_q.delete();
        reset = 1'b0;
        drive();
        step();
        push_frame(0, 13, 1);
        run(6);
        chki("t5_flits", pq_log.size() - base, 2);
        chkd("t5_fresh", pq_log[pq_log.size() - 1], flit(13, 0, 1));
        chki("t5_grants", g_log.size() - gbase, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/smi_arb_2to1.md
SMI_ARB_2TO1 -- requirements
Module: smi_arb_2to1

Interface
REQ-001 The block SHALL have one parameter: OUTSTANDING_LOG2, default 2, log2 of the maximum number of request frames in flight awaiting a response.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset as the codebase does.
REQ-003 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  input  1  system clock, all logic on the rising edge.
- reset  input  1  synchronous active-high reset.
- smireqa_0Ready / smireqa_0Data / smireqa_0Stop  in / in / out  1 / 72 / 1  requester A request channel.
- smireqb_0Ready / smireqb_0Data / smireqb_0Stop  in / in / out  1 / 72 / 1  requester B request channel.
- smirespa_0Ready / smirespa_0Data / smirespa_0Stop  out / out / in  1 / 72 / 1  requester A response channel.
- smirespb_0Ready / smirespb_0Data / smirespb_0Stop  out / out / in  1 / 72 / 1  requester B response channel.
- smiportreq_0Ready / smiportreq_0Data / smiportreq_0Stop  out / out / in  1 / 72 / 1  shared memory-side request channel.
- smiportresp_0Ready / smiportresp_0Data / smiportresp_0Stop  in / in / out  1 / 72 / 1  shared memory-side response channel.

Function
REQ-004 A flit SHALL transfer on any cycle where Ready=1 and Stop=0; a sender SHALL hold Ready and Data stable until the flit transfers.
REQ-005 Data[64] SHALL be the end-of-frame (EOF) bit; a frame is one or more flits ending with EOF=1; Data SHALL pass through unmodified.
REQ-006 The request FSM SHALL have the states IDLE, FWD_A and FWD_B.
REQ-007 In IDLE: no request Ready is forwarded, and smireqa_0Stop=smireqb_0Stop=1.
REQ-008 IDLE -> FWD_x SHALL occur on the clock edge where at least one requester has Ready=1 and the outstanding count is below 2^OUTSTANDING_LOG2; x is the arbitration winner.
REQ-009 In FWD_x: smiportreq_0Ready/Data SHALL combinationally equal requester x's Ready/Data, smireqx_0Stop SHALL equal smiportreq_0Stop, and the other requester's Stop SHALL be 1.
REQ-010 FWD_x -> IDLE SHALL occur on transfer of a flit with EOF=1; a grant SHALL never change mid-frame.
REQ-011 Arbitration latency: the first flit SHALL be presented on smiportreq one cycle after Ready is first seen in IDLE; back-to-back frames SHALL incur one IDLE cycle between them.
REQ-012 On each IDLE -> FWD_x transition, the winner ID (0=A, 1=B) SHALL be pushed into an in-order ID FIFO of depth 2^OUTSTANDING_LOG2.
REQ-013 When the ID FIFO is full, the FSM SHALL remain in IDLE regardless of requests.
REQ-014 Response frames SHALL be routed to the requester at the head of the ID FIFO:
- smirespx_0Ready = smiportresp_0Ready for that requester; the other requester's Ready = 0.
- smiportresp_0Stop = the selected requester's Stop.
REQ-015 The head ID SHALL be popped on transfer of a response flit with EOF=1.
REQ-016 With the ID FIFO empty: smiportresp_0Stop=1 and both smirespa_0Ready and smirespb_0Ready = 0.
REQ-017 A simultaneous push and pop SHALL leave the outstanding count unchanged.
REQ-018 A request may be pushed while the FIFO holds 2^OUTSTANDING_LOG2-1 entries even if a pop occurs in the same cycle.
REQ-019 Response Data SHALL be driven to both requester response Data outputs; only Ready is steered.

Reset
REQ-020 On reset=1 at a clock edge, regardless of state:
- the FSM SHALL enter IDLE;
- the ID FIFO SHALL be emptied and the round-robin pointer set to favour A;
- any in-progress frame SHALL be abandoned.
REQ-021 During and immediately after reset, outputs SHALL be:
- smiportreq_0Ready=0, smirespa_0Ready=0, smirespb_0Ready=0;
- smiportresp_0Stop=1, smireqa_0Stop=1, smireqb_0Stop=1;
- all Data outputs driven per REQ-009/REQ-019, not otherwise defined.

Configuration
REQ-022 With macro SMI_ARB_FIXED_PRIORITY_EN defined, A SHALL always win when both requesters are ready.
REQ-023 With SMI_ARB_FIXED_PRIORITY_EN undefined, arbitration SHALL be round-robin:
- on a tie, the requester not granted most recently wins;
- a lone requester always wins;
- the pointer updates only on a grant.

Verification
REQ-024 Test: A sends one 3-flit frame, B idle -> smiportreq carries 3 flits starting one cycle after A Ready; A's response of 2 flits appears only on smirespa.
REQ-025 Test: A and B both ready with single-flit frames repeatedly, round-robin build -> grants alternate A,B,A,B; fixed-priority build -> A, A, A until A drops Ready.
REQ-026 Test: smiportreq_0Stop=1 mid-frame of A while B ready -> A's remaining flits held stable, B not granted until A EOF transfers.
REQ-027 Test: OUTSTANDING_LOG2=2, five frames issued with no responses -> fifth held in IDLE with Stop=1; one response EOF -> fifth granted the next cycle.
REQ-028 Test: responses returned for order A,B,A -> routed to smirespa, smirespb, smirespa; a response presented with an empty FIFO -> smiportresp_0Stop=1.
REQ-029 Test: reset asserted during the second flit of a 4-flit frame -> next cycle all Ready outputs = 0, FIFO empty, and the next request is granted as a fresh frame.
